// File: rtl/stopwatch_counter_pkg.sv
// Shared constants and encodings for the endless-mode stopwatch.
// STATE_ENDLESS must match the game-mode encoding used by the controller and the display.
package stopwatch_counter_pkg;

   localparam logic [1:0] STATE_ENDLESS = 2'd2;
   localparam logic [3:0] BCD_NINE      = 4'd9;

   typedef enum logic [1:0] {
      SW_IDLE  = 2'd0,
      SW_RUN   = 2'd1,
      SW_PAUSE = 2'd2,
      SW_MAXED = 2'd3
   } sw_state_t;

endpackage

// File: rtl/stopwatch_counter_bcd_digit.sv
// One mod-10 BCD digit; carry is combinational so a chain of digits ripples in one edge.
module stopwatch_counter_bcd_digit
   import stopwatch_counter_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       clr,
   input  logic       inc,
   output logic [3:0] q,
   output logic       carry
);

   logic [3:0] r_q;
   logic       w_at_nine;

   assign w_at_nine = (r_q == BCD_NINE);

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         r_q <= 4'd0;
      end else if (inc) begin
         r_q <= w_at_nine ? 4'd0 : r_q + 4'd1;
      end
   end

   assign q     = r_q;
   assign carry = inc & w_at_nine;

endmodule

// File: rtl/stopwatch_counter.sv
// Endless-mode stopwatch: 10 ms prescaler, IDLE/RUN/PAUSE/MAXED FSM and a 4-digit BCD chain
// counting 00.00 .. 99.99, saturating at the top.
module stopwatch_counter
   import stopwatch_counter_pkg::*;
#(
   parameter int TICK_CYCLES = 1_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] level,
   input  logic       start,
   input  logic       pause,
   input  logic       clear,
   output logic [3:0] sec_ten,
   output logic [3:0] sec_uni,
   output logic [3:0] msec_ten,
   output logic [3:0] msec_uni,
   output logic       running,
   output logic       time_max
);

   localparam int              PW      = $clog2(TICK_CYCLES);
   localparam logic [PW-1:0]   TC_LAST = PW'(TICK_CYCLES - 1);

   sw_state_t     r_state;
   sw_state_t     w_state_next;
   logic [PW-1:0] r_presc;
   logic [PW-1:0] w_presc_next;
   logic          r_running;
   logic          r_time_max;

   logic          w_live;
   logic          w_start;
   logic          w_pause;
   logic          w_tc;
   logic          w_adv;
   logic          w_sat;
   logic          w_digit_clr;

   logic [3:0]    w_digit [4];
   logic [4:0]    w_inc_chain;

   // start and pause arriving together cancel each other out
   assign w_live      = (level == STATE_ENDLESS);
   assign w_start     = start & ~pause;
   assign w_pause     = pause & ~start;
   assign w_tc        = (r_presc == TC_LAST);
   assign w_adv       = w_live & ~clear & (r_state == SW_RUN) & ~w_pause & w_tc;
   assign w_sat       = w_adv && (w_digit[3] == BCD_NINE) && (w_digit[2] == BCD_NINE)
                        && (w_digit[1] == BCD_NINE) && (w_digit[0] == 4'd8);
   assign w_digit_clr = ~w_live | clear;

   // State register, plus outputs registered from the next state so they track it exactly
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= SW_IDLE;
         r_presc    <= '0;
         r_running  <= 1'b0;
         r_time_max <= 1'b0;
      end else begin
         r_state    <= w_state_next;
         r_presc    <= w_presc_next;
         r_running  <= (w_state_next == SW_RUN);
         r_time_max <= (w_state_next == SW_MAXED);
      end
   end

   always_comb begin
      w_state_next = r_state;
      if (!w_live || clear) begin
         w_state_next = SW_IDLE;
      end else begin
         case (r_state)
            SW_IDLE:  if (w_start) w_state_next = SW_RUN;
            SW_RUN: begin
               if (w_pause)    w_state_next = SW_PAUSE;
               else if (w_sat) w_state_next = SW_MAXED;
            end
            SW_PAUSE: if (w_start) w_state_next = SW_RUN;
            SW_MAXED: w_state_next = SW_MAXED;
            default:  w_state_next = SW_IDLE;
         endcase
      end
   end

   // A pause on the terminal-count edge freezes the prescaler at TC_LAST, so resume advances at once
   always_comb begin
      w_presc_next = r_presc;
      if (!w_live || clear || (r_state == SW_IDLE)) begin
         w_presc_next = '0;
      end else if ((r_state == SW_RUN) && !w_pause) begin
         w_presc_next = w_tc ? '0 : r_presc + PW'(1);
      end
   end

   assign w_inc_chain[0] = w_adv;

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_digit
         stopwatch_counter_bcd_digit u_digit (
            .clk   (clk),
            .rst   (rst),
            .clr   (w_digit_clr),
            .inc   (w_inc_chain[gi]),
            .q     (w_digit[gi]),
            .carry (w_inc_chain[gi+1])
         );
      end
   endgenerate

   assign msec_uni = w_digit[0];
   assign msec_ten = w_digit[1];
   assign sec_uni  = w_digit[2];
   assign sec_ten  = w_digit[3];
   assign running  = r_running;
   assign time_max = r_time_max;

endmodule

// File: tb/tb_stopwatch_counter.sv
// Directed bench for stopwatch_counter with TICK_CYCLES = 4: a vector table plus a pause-hold sequence.
module tb_stopwatch_counter;
   import stopwatch_counter_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [1:0] level = STATE_ENDLESS;
   logic       start = 1'b0;
   logic       pause = 1'b0;
   logic       clear = 1'b0;
   logic [3:0] sec_ten, sec_uni, msec_ten, msec_uni;
   logic       running, time_max;

   int n_cmp = 0;
   int n_bad = 0;

   stopwatch_counter #(.TICK_CYCLES(4)) dut (
      .clk      (clk),
      .rst      (rst),
      .level    (level),
      .start    (start),
      .pause    (pause),
      .clear    (clear),
      .sec_ten  (sec_ten),
      .sec_uni  (sec_uni),
      .msec_ten (msec_ten),
      .msec_uni (msec_uni),
      .running  (running),
      .time_max (time_max)
   );

   always #5 clk = ~clk;

   // One record: drive inputs for one edge, then idle for the rest of cyc edges, then compare.
   typedef struct {
      string      name;
      logic       rst;
      logic [1:0] lvl;
      logic       st;
      logic       pa;
      logic       cl;
      int         cyc;
      logic [15:0] val;
      logic       run;
      logic       tmax;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(string name, logic r, logic [1:0] lvl, logic st, logic pa,
                               logic cl, int cyc, logic [15:0] val, logic run, logic tmax);
      vec_t v;
      v.name = name; v.rst = r; v.lvl = lvl; v.st = st; v.pa = pa; v.cl = cl;
      v.cyc = cyc; v.val = val; v.run = run; v.tmax = tmax;
      return v;
   endfunction

   task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic apply(input vec_t v);
      @(negedge clk);
      rst = v.rst; level = v.lvl; start = v.st; pause = v.pa; clear = v.cl;
      @(posedge clk);
      #1;
      rst = 1'b0; start = 1'b0; pause = 1'b0; clear = 1'b0;
      repeat (v.cyc - 1) @(posedge clk);
      #1;
   endtask

   task automatic check_all(input string name, input logic [15:0] val, input logic run,
                            input logic tmax);
      check({name, ".val"}, {sec_ten, sec_uni, msec_ten, msec_uni}, val);
      check({name, ".running"}, {15'd0, running}, {15'd0, run});
      check({name, ".time_max"}, {15'd0, time_max}, {15'd0, tmax});
      $display("vec %-16s val=%h run=%b max=%b", name,
               {sec_ten, sec_uni, msec_ten, msec_uni}, running, time_max);
   endtask

   localparam logic [1:0] LV_E = STATE_ENDLESS;
   localparam logic [1:0] LV_X = 2'd0;

   initial begin
      //                 name            rst lvl  st pa cl cyc    value     run max
      vecs.push_back(mk("reset",          1, LV_E, 0, 0, 0, 1,     16'h0000, 0, 0));
      vecs.push_back(mk("start",          0, LV_E, 1, 0, 0, 1,     16'h0000, 1, 0));
      vecs.push_back(mk("first_tick",     0, LV_E, 0, 0, 0, 4,     16'h0001, 1, 0));
      vecs.push_back(mk("t40",            0, LV_E, 0, 0, 0, 36,    16'h0010, 1, 0));
      vecs.push_back(mk("t400",           0, LV_E, 0, 0, 0, 360,   16'h0100, 1, 0));
      vecs.push_back(mk("at_0999",        0, LV_E, 0, 0, 0, 3596,  16'h0999, 1, 0));
      vecs.push_back(mk("pre_carry",      0, LV_E, 0, 0, 0, 3,     16'h0999, 1, 0));
      vecs.push_back(mk("carry_edge",     0, LV_E, 0, 0, 0, 1,     16'h1000, 1, 0));
      vecs.push_back(mk("at_9998",        0, LV_E, 0, 0, 0, 35995, 16'h9998, 1, 0));
      vecs.push_back(mk("saturate",       0, LV_E, 0, 0, 0, 1,     16'h9999, 0, 1));
      vecs.push_back(mk("max_start_hold", 0, LV_E, 1, 0, 0, 100,   16'h9999, 0, 1));
      vecs.push_back(mk("max_pause",      0, LV_E, 0, 1, 0, 1,     16'h9999, 0, 1));
      vecs.push_back(mk("max_clear",      0, LV_E, 0, 0, 1, 1,     16'h0000, 0, 0));
      vecs.push_back(mk("start2",         0, LV_E, 1, 0, 0, 1,     16'h0000, 1, 0));
      vecs.push_back(mk("to_0005_p2",     0, LV_E, 0, 0, 0, 22,    16'h0005, 1, 0));
      vecs.push_back(mk("pause_hold50",   0, LV_E, 0, 1, 0, 50,    16'h0005, 0, 0));
      vecs.push_back(mk("resume",         0, LV_E, 1, 0, 0, 1,     16'h0005, 1, 0));
      vecs.push_back(mk("resume+1",       0, LV_E, 0, 0, 0, 1,     16'h0005, 1, 0));
      vecs.push_back(mk("resume+2",       0, LV_E, 0, 0, 0, 1,     16'h0006, 1, 0));
      vecs.push_back(mk("to_tc",          0, LV_E, 0, 0, 0, 3,     16'h0006, 1, 0));
      vecs.push_back(mk("pause_on_tc",    0, LV_E, 0, 1, 0, 5,     16'h0006, 0, 0));
      vecs.push_back(mk("resume_tc",      0, LV_E, 1, 0, 0, 1,     16'h0006, 1, 0));
      vecs.push_back(mk("first_run_edge", 0, LV_E, 0, 0, 0, 1,     16'h0007, 1, 0));
      vecs.push_back(mk("run5",           0, LV_E, 0, 0, 0, 5,     16'h0008, 1, 0));
      vecs.push_back(mk("clear_start",    0, LV_E, 1, 0, 1, 1,     16'h0000, 0, 0));
      vecs.push_back(mk("idle_hold",      0, LV_E, 0, 0, 0, 10,    16'h0000, 0, 0));
      vecs.push_back(mk("idle_st_pa",     0, LV_E, 1, 1, 0, 1,     16'h0000, 0, 0));
      vecs.push_back(mk("idle_st_pa_8",   0, LV_E, 0, 0, 0, 8,     16'h0000, 0, 0));
      vecs.push_back(mk("start3",         0, LV_E, 1, 0, 0, 1,     16'h0000, 1, 0));
      vecs.push_back(mk("run9",           0, LV_E, 0, 0, 0, 9,     16'h0002, 1, 0));
      vecs.push_back(mk("level_away",     0, LV_X, 0, 0, 0, 1,     16'h0000, 0, 0));
      vecs.push_back(mk("away_start",     0, LV_X, 1, 0, 0, 5,     16'h0000, 0, 0));
      vecs.push_back(mk("level_back",     0, LV_E, 0, 0, 0, 5,     16'h0000, 0, 0));
      vecs.push_back(mk("start4",         0, LV_E, 1, 0, 0, 1,     16'h0000, 1, 0));
      vecs.push_back(mk("run_st_pa",      0, LV_E, 1, 1, 0, 4,     16'h0001, 1, 0));
      vecs.push_back(mk("clear2",         0, LV_E, 0, 0, 1, 1,     16'h0000, 0, 0));
      vecs.push_back(mk("start5",         0, LV_E, 1, 0, 0, 1,     16'h0000, 1, 0));
      vecs.push_back(mk("to_3742",        0, LV_E, 0, 0, 0, 14968, 16'h3742, 1, 0));
      vecs.push_back(mk("reset_mid_run",  1, LV_E, 0, 0, 0, 1,     16'h0000, 0, 0));
      vecs.push_back(mk("post_reset",     0, LV_E, 0, 0, 0, 5,     16'h0000, 0, 0));

      repeat (2) @(posedge clk);
      foreach (vecs[i]) begin
         apply(vecs[i]);
         check_all(vecs[i].name, vecs[i].val, vecs[i].run, vecs[i].tmax);
      end

      // Hand-written: value must stay frozen on every cycle of a pause
      apply(mk("seq_start", 0, LV_E, 1, 0, 0, 6, 16'h0001, 1, 0));
      check_all("seq_run", 16'h0001, 1'b1, 1'b0);
      apply(mk("seq_pause", 0, LV_E, 0, 1, 0, 1, 16'h0001, 0, 0));
      for (int k = 0; k < 20; k++) begin
         check({"seq_hold.val"}, {sec_ten, sec_uni, msec_ten, msec_uni}, 16'h0001);
         check({"seq_hold.running"}, {15'd0, running}, 16'h0000);
         @(posedge clk);
         #1;
      end
      $display("seq pause hold done val=%h run=%b", {sec_ten, sec_uni, msec_ten, msec_uni},
               running);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
